// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: registers fetched IR/next-PC and drives execute,
// writeback and memory control encodings plus a valid flag to execute.
//
// Ports:
//   clock, reset (async, active-low)
//   enable_decode, flush                 capture / squash controls
//   dout[15:0], npc_in[15:0]             fetched instruction and PC+1
//   IR, npc_out                          captured instruction and PC+1
//   E_Control[5:0]  {alu[1:0], pcsel1[1:0], pcsel2, op2sel}
//   W_Control[1:0]  00 aluout, 01 memout, 10 pcout
//   Mem_Control     0 direct, 1 indirect
//   decode_valid    outputs hold a live decoded instruction
//   illegal_op      only when DECODE_ILLEGAL_OP_EN is defined
module lc3_decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic        flush,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control,
    output logic        decode_valid
`ifdef DECODE_ILLEGAL_OP_EN
    ,
    output logic        illegal_op
`endif
);

    logic [3:0] opcode;
    logic       imm;
    logic [5:0] e_nxt;
    logic [1:0] w_nxt;
    logic       m_nxt;
`ifdef DECODE_ILLEGAL_OP_EN
    logic       ill_nxt;
`endif

    assign opcode = dout[15:12];
    assign imm    = dout[5];

    logic is_add, is_and, is_not, is_br, is_jmp, is_ld;
    logic is_ldr, is_ldi, is_lea, is_st, is_str, is_sti;

    assign is_add = (opcode == 4'b0001);
    assign is_and = (opcode == 4'b0101);
    assign is_not = (opcode == 4'b1001);
    assign is_br  = (opcode == 4'b0000);
    assign is_jmp = (opcode == 4'b1100);
    assign is_ld  = (opcode == 4'b0010);
    assign is_ldr = (opcode == 4'b0110);
    assign is_ldi = (opcode == 4'b1010);
    assign is_lea = (opcode == 4'b1110);
    assign is_st  = (opcode == 4'b0011);
    assign is_str = (opcode == 4'b0111);
    assign is_sti = (opcode == 4'b1011);

    // op2select is 1 for register operand, so it is the inverse of
    // the immediate flag in IR[5].
    always_comb begin
        e_nxt = 6'b000000;
        w_nxt = 2'b00;
        m_nxt = 1'b0;
`ifdef DECODE_ILLEGAL_OP_EN
        ill_nxt = 1'b0;
`endif
        unique case (1'b1)
            is_add: e_nxt = {2'b00, 2'b00, 1'b0, ~imm};
            is_and: e_nxt = {2'b01, 2'b00, 1'b0, ~imm};
            is_not: e_nxt = {2'b10, 2'b00, 1'b0, 1'b0};
            is_br:  e_nxt = {2'b00, 2'b01, 1'b1, 1'b0};
            is_jmp: e_nxt = {2'b00, 2'b11, 1'b0, 1'b0};
            is_ld: begin
                e_nxt = {2'b00, 2'b01, 1'b1, 1'b0};
                w_nxt = 2'b01;
            end
            is_ldr: begin
                e_nxt = {2'b00, 2'b10, 1'b0, 1'b0};
                w_nxt = 2'b01;
            end
            is_ldi: begin
                e_nxt = {2'b00, 2'b01, 1'b1, 1'b0};
                w_nxt = 2'b01;
                m_nxt = 1'b1;
            end
            is_lea: begin
                e_nxt = {2'b00, 2'b01, 1'b1, 1'b0};
                w_nxt = 2'b10;
            end
            is_st:  e_nxt = {2'b00, 2'b01, 1'b1, 1'b0};
            is_str: e_nxt = {2'b00, 2'b10, 1'b0, 1'b0};
            is_sti: begin
                e_nxt = {2'b00, 2'b01, 1'b1, 1'b0};
                m_nxt = 1'b1;
            end
            // JSR, RTI, reserved and TRAP: zero controls
            default: begin
`ifdef DECODE_ILLEGAL_OP_EN
                ill_nxt = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            IR           <= 16'h0000;
            npc_out      <= 16'h0000;
            E_Control    <= 6'b000000;
            W_Control    <= 2'b00;
            Mem_Control  <= 1'b0;
            decode_valid <= 1'b0;
        end else if (flush) begin
            IR           <= 16'h0000;
            npc_out      <= 16'h0000;
            E_Control    <= 6'b000000;
            W_Control    <= 2'b00;
            Mem_Control  <= 1'b0;
            decode_valid <= 1'b0;
        end else if (enable_decode) begin
            IR           <= dout;
            npc_out      <= npc_in;
            E_Control    <= e_nxt;
            W_Control    <= w_nxt;
            Mem_Control  <= m_nxt;
            decode_valid <= 1'b1;
        end
    end

`ifdef DECODE_ILLEGAL_OP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            illegal_op <= 1'b0;
        end else if (flush) begin
            illegal_op <= 1'b0;
        end else if (enable_decode) begin
            illegal_op <= ill_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Scoreboard bench for lc3_decode_stage: a driver pushes expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_lc3_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_decode = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] dout = 16'h0000;
    logic [15:0] npc_in = 16'h0000;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        decode_valid;
`ifdef DECODE_ILLEGAL_OP_EN
    logic        illegal_op;
`endif

    lc3_decode_stage dut (
        .clock(clock),
        .reset(reset),
        .enable_decode(enable_decode),
        .flush(flush),
        .dout(dout),
        .npc_in(npc_in),
        .IR(IR),
        .npc_out(npc_out),
        .E_Control(E_Control),
        .W_Control(W_Control),
        .Mem_Control(Mem_Control),
        .decode_valid(decode_valid)
`ifdef DECODE_ILLEGAL_OP_EN
        ,
        .illegal_op(illegal_op)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        v;
        logic        il;
    } exp_t;

    exp_t q[$];
    exp_t mdl;
    int   checks = 0;
    int   errors = 0;
    int   item = 0;

    // Reference: classify the instruction by what it does, then derive
    // each control field from that class.
    function automatic exp_t ref_decode(logic [15:0] d, logic [15:0] n);
        exp_t r;
        int   op;
        bit   alu_op, pc_rel, base_rel, is_load, indirect;
        op = int'(d[15:12]);
        r = '0;
        r.ir  = d;
        r.npc = n;
        r.v   = 1'b1;
        alu_op   = (op == 1) || (op == 5) || (op == 9);
        pc_rel   = (op == 0) || (op == 2) || (op == 10) ||
                   (op == 14) || (op == 3) || (op == 11);
        base_rel = (op == 6) || (op == 7);
        is_load  = (op == 2) || (op == 6) || (op == 10);
        indirect = (op == 10) || (op == 11);
        if (op == 5) r.e[5:4] = 2'd1;
        if (op == 9) r.e[5:4] = 2'd2;
        if (pc_rel) r.e[3:1] = 3'b011;
        if (base_rel) r.e[3:1] = 3'b100;
        if (op == 12) r.e[3:1] = 3'b110;
        if (alu_op && op != 9 && d[5] == 1'b0) r.e[0] = 1'b1;
        if (is_load) r.w = 2'd1;
        if (op == 14) r.w = 2'd2;
        r.m = indirect;
`ifdef DECODE_ILLEGAL_OP_EN
        r.il = (op == 4) || (op == 8) || (op == 13) || (op == 15);
`endif
        return r;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.ir  = IR;
        a.npc = npc_out;
        a.e   = E_Control;
        a.w   = W_Control;
        a.m   = Mem_Control;
        a.v   = decode_valid;
`ifdef DECODE_ILLEGAL_OP_EN
        a.il  = illegal_op;
`else
        a.il  = 1'b0;
`endif
        return a;
    endfunction

    task automatic report(string name, exp_t a, exp_t e);
        $display("FAIL %s: got IR=%h npc=%h E=%b W=%b M=%b V=%b IL=%b, want IR=%h npc=%h E=%b W=%b M=%b V=%b IL=%b",
                 name, a.ir, a.npc, a.e, a.w, a.m, a.v, a.il,
                 e.ir, e.npc, e.e, e.w, e.m, e.v, e.il);
    endtask

    task automatic check_now(string name, exp_t e);
        exp_t a;
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            report(name, a, e);
        end
    endtask

    task automatic cycle(logic en, logic fl, logic [15:0] d, logic [15:0] n);
        @(negedge clock);
        enable_decode = en;
        flush = fl;
        dout = d;
        npc_in = n;
        @(posedge clock);
        if (fl) mdl = '0;
        else if (en) mdl = ref_decode(d, n);
        q.push_back(mdl);
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = q.pop_front();
            a = actual();
            item++;
            checks++;
            if (a !== e) begin
                errors++;
                report($sformatf("scoreboard#%0d", item), a, e);
            end
        end
    end

    initial begin
        mdl = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1 check_now("reset_state", '0);

        cycle(1'b0, 1'b0, 16'h1234, 16'h5678);
        cycle(1'b0, 1'b0, 16'hFFFF, 16'hAAAA);

        cycle(1'b1, 1'b0, 16'h12A3, 16'h3001);
        cycle(1'b1, 1'b0, 16'h1283, 16'h3002);
        cycle(1'b1, 1'b0, 16'h6283, 16'h3003);
        cycle(1'b1, 1'b0, 16'hA201, 16'h3004);
        cycle(1'b1, 1'b0, 16'hE205, 16'h3005);
        cycle(1'b1, 1'b0, 16'h927F, 16'h3006);
        cycle(1'b1, 1'b0, 16'h5262, 16'h3007);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 16'($urandom), 16'($urandom));
        cycle(1'b1, 1'b1, 16'hB001, 16'h3008);
        cycle(1'b1, 1'b0, 16'hF025, 16'h3009);
        cycle(1'b1, 1'b0, 16'h2001, 16'h300A);
        cycle(1'b1, 1'b0, 16'hC1C0, 16'h300B);
        cycle(1'b1, 1'b0, 16'h0E05, 16'h300C);
        cycle(1'b1, 1'b0, 16'h4800, 16'h300D);
        cycle(1'b1, 1'b0, 16'h3401, 16'h300E);
        cycle(1'b1, 1'b0, 16'h7441, 16'h300F);
        cycle(1'b1, 1'b0, 16'hB601, 16'h3010);
        cycle(1'b1, 1'b0, 16'h8000, 16'h3011);
        cycle(1'b1, 1'b0, 16'hD000, 16'h3012);

        cycle(1'b1, 1'b0, 16'h12A3, 16'h4000);
        cycle(1'b0, 1'b0, 16'h12A3, 16'h4001);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check_now("reset_async", '0);
        mdl = '0;
        @(negedge clock);
        check_now("reset_hold", '0);
        reset = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic en;
            logic fl;
            en = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 9) == 0);
            cycle(en, fl, 16'($urandom), 16'($urandom));
        end

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clock);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
